tqvp_spi_fifo: RTL and testbench
================================

// Module: tqvp_spi_fifo
// PURPOSE
// - Byte queueing stage between the TinyQV register interface and the tqvp_spi_ctrl engine.
// - TX FIFO: buffers bytes plus per-byte DC/end_txn flags and drives one-cycle start pulses
//   into the SPI controller back-to-back.
// - RX FIFO: captures the controller's data_out after every completed byte.
// - Lets software write a burst (e.g. an LCD command + params) without polling busy per byte.
// PARAMETERS
// - DEPTH       4  entries per FIFO; power of 2, 2..16
// - RX_CAPTURE  1  1 = store received bytes in RX FIFO; 0 = RX FIFO never written (always empty)
// PORTS
// - clk          in   1      system clock
// - rst_n        in   1      asynchronous active-low reset
// - tx_wr        in   1      push {tx_dc, tx_end, tx_data} into TX FIFO
// - tx_data      in   8      byte to transmit
// - tx_dc        in   1      DC level for this byte
// - tx_end       in   1      release CS after this byte
// - tx_full      out  1      TX FIFO holds DEPTH entries
// - tx_level     out  CW     TX entries held, CW = $clog2(DEPTH)+1
// - rx_rd        in   1      pop RX FIFO head
// - rx_data      out  8      RX FIFO head (combinational from storage; 0 when empty)
// - rx_empty     out  1      RX FIFO holds no entries
// - rx_level     out  CW     RX entries held
// - flush        in   1      synchronous clear of both FIFOs and sticky flags
// - tx_ovf       out  1      sticky: push attempted while tx_full
// - rx_ovf       out  1      sticky: byte dropped because RX FIFO full
// - idle         out  1      TX FIFO empty and FSM in IDLE
// - spi_start    out  1      to ctrl start; registered one-cycle pulse
// - spi_data     out  8      to ctrl data_in; held from pop until next pop
// - spi_dc       out  1      to ctrl dc_in
// - spi_end_txn  out  1      to ctrl end_txn
// - spi_busy     in   1      from ctrl busy
// - spi_rx       in   8      from ctrl data_out; valid when spi_busy low
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFOs empty, pointers 0, FSM=IDLE, spi_start=0, spi_data=0,
//   spi_dc=0, spi_end_txn=1, tx_ovf=rx_ovf=0, discard=0; tx_full=0, rx_empty=1, idle=1.
//   Reset mid-transfer abandons the byte; no capture.
// - FIFOs: circular, pointers wrap modulo DEPTH; level = 0..DEPTH, CW bits.
// - TX push: accepted iff !tx_full (pre-pop count) and !flush; rejected push sets tx_ovf.
//   Push while full is rejected even if a pop occurs the same cycle.
// - RX pop: rx_rd with rx_empty is ignored. Simultaneous RX capture and rx_rd when full:
//   capture accepted, no overflow.
// - FSM states: IDLE, WAIT_BUSY, XFER.
//   - IDLE: if tx_level!=0 && !spi_busy && !flush, then at the edge pop TX head into
//     spi_data/dc/end_txn, set spi_start=1 for exactly one cycle, go to WAIT_BUSY.
//   - WAIT_BUSY: when spi_busy=1, go to XFER.
//   - XFER: when spi_busy=0, capture spi_rx into RX FIFO (if RX_CAPTURE && !discard),
//     clear discard, go to IDLE. RX full at capture: byte dropped, rx_ovf set.
// - Latency: push into empty idle FIFO -> spi_start high 2 cycles after tx_wr
//   (1 cycle to land in FIFO, 1 for registered start).
// - Inter-byte gap: start follows the cycle after XFER exits (min 1 idle cycle).
// - flush: empties both FIFOs, clears tx_ovf/rx_ovf, suppresses any push/pop that cycle.
//   If FSM is in WAIT_BUSY/XFER, the in-flight byte completes on the wire and discard=1
//   drops its RX capture.
// - spi_data/dc/end_txn change only on a pop, so they are stable while ctrl is busy.
// TESTING
// - Push 0xA5 (dc=1, end=1) into empty FIFO -> spi_start pulse 2 cycles later, one cycle
//   wide, with spi_data=A5, spi_dc=1, spi_end_txn=1; after busy falls, rx_level=1 and
//   rx_data=spi_rx.
// - Push 5 bytes with DEPTH=4 while spi_busy held 1 -> tx_full after 4 pushes, 5th
//   rejected, tx_ovf=1, tx_level=4; release busy -> 4 starts in FIFO order 01,02,03,04.
// - Run 5 transfers without rx_rd (DEPTH=4) -> rx_level=4, rx_ovf=1, rx_data=first byte.
// - Assert flush while FSM in XFER with 2 queued -> tx_level=0 next cycle; no further
//   start; completed byte not captured (rx_level unchanged).
// - Capture and rx_rd in same cycle with RX full -> rx_level stays 4, rx_ovf=0, head advances.
// - Deassert rst_n mid-XFER -> all outputs at reset values immediately (asynchronous);
//   after release, idle=1 and no spurious start.

Source files
------------

// File: rtl/tqvp_spi_fifo.sv
// tqvp_spi_fifo: TX/RX byte queues in front of the SPI controller.
// Queued TX bytes become back-to-back start pulses; each completed byte is captured into RX.
module tqvp_spi_fifo #(
  parameter int DEPTH      = 4,
  parameter bit RX_CAPTURE = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_wr,
  input  logic [7:0]    tx_data,
  input  logic          tx_dc,
  input  logic          tx_end,
  output logic          tx_full,
  output logic [CW-1:0] tx_level,
  input  logic          rx_rd,
  output logic [7:0]    rx_data,
  output logic          rx_empty,
  output logic [CW-1:0] rx_level,
  input  logic          flush,
  output logic          tx_ovf,
  output logic          rx_ovf,
  output logic          idle,
  output logic          spi_start,
  output logic [7:0]    spi_data,
  output logic          spi_dc,
  output logic          spi_end_txn,
  input  logic          spi_busy,
  input  logic [7:0]    spi_rx
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    XFER
  } state_e;

  state_e state_q, state_d;

  logic [9:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d;
  logic [AW-1:0] tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d;
  logic [AW-1:0] rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;

  logic tx_ovf_q, tx_ovf_d;
  logic rx_ovf_q, rx_ovf_d;
  logic discard_q, discard_d;

  logic       start_q;
  logic [7:0] data_q;
  logic       dc_q;
  logic       end_q;

  logic tx_is_full, rx_is_full;
  logic tx_push, tx_pop;
  logic xfer_done, rx_pop;
  logic rx_cap, rx_store, rx_drop;

  // Qualify this cycle's pushes, pops and captures; flush suppresses all of them
  always_comb begin
    tx_is_full = (tx_cnt_q == CW'(DEPTH));
    rx_is_full = (rx_cnt_q == CW'(DEPTH));
    tx_push    = tx_wr && !tx_is_full && !flush;
    tx_pop     = (state_q == IDLE) && (tx_cnt_q != '0)
                 && !spi_busy && !flush;
    xfer_done  = (state_q == XFER) && !spi_busy;
    rx_pop     = rx_rd && (rx_cnt_q != '0) && !flush;
    rx_cap     = xfer_done && RX_CAPTURE && !discard_q && !flush;
    rx_store   = rx_cap && (!rx_is_full || rx_pop);
    rx_drop    = rx_cap && rx_is_full && !rx_pop;
  end

  // Transfer sequencing: issue, wait for busy to rise, wait for busy to fall
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (tx_pop) state_d = WAIT_BUSY;
      WAIT_BUSY: if (spi_busy) state_d = XFER;
      XFER:      if (!spi_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Pointer, level and sticky-flag next state
  always_comb begin
    tx_wp_d   = tx_wp_q;
    tx_rp_d   = tx_rp_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    rx_cnt_d  = rx_cnt_q;
    tx_ovf_d  = tx_ovf_q | (tx_wr & tx_is_full);
    rx_ovf_d  = rx_ovf_q | rx_drop;
    discard_d = discard_q;
    if (flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
      if (state_q != IDLE) discard_d = 1'b1;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_store) rx_wp_d = rx_wp_q + AW'(1);
      if (rx_pop)   rx_rp_d = rx_rp_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_store) - CW'(rx_pop);
    end
    if (xfer_done) discard_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      discard_q <= discard_d;
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      if (tx_push) tx_mem_q[tx_wp_q] <= {tx_dc, tx_end, tx_data};
      if (rx_store) rx_mem_q[rx_wp_q] <= spi_rx;
    end
  end

  // Controller-facing byte and flags only move on a pop, start is a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      end_q   <= 1'b1;
    end else begin
      start_q <= tx_pop;
      if (tx_pop) begin
        {dc_q, end_q, data_q} <= tx_mem_q[tx_rp_q];
      end
    end
  end

  assign tx_full     = tx_is_full;
  assign tx_level    = tx_cnt_q;
  assign rx_level    = rx_cnt_q;
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_data     = (rx_cnt_q != '0) ? rx_mem_q[rx_rp_q] : 8'h00;
  assign tx_ovf      = tx_ovf_q;
  assign rx_ovf      = rx_ovf_q;
  assign idle        = (tx_cnt_q == '0) && (state_q == IDLE);
  assign spi_start   = start_q;
  assign spi_data    = data_q;
  assign spi_dc      = dc_q;
  assign spi_end_txn = end_q;

endmodule

// File: tb/tb_tqvp_spi_fifo.sv
// tb_tqvp_spi_fifo: scoreboard bench with a behavioural SPI controller model.
// Directed scenarios first, then randomized back-to-back traffic with random RX draining.
module tb_tqvp_spi_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_wr = 1'b0;
  logic [7:0]    tx_data = '0;
  logic          tx_dc = 1'b0;
  logic          tx_end = 1'b0;
  logic          tx_full;
  logic [CW-1:0] tx_level;
  logic          rx_rd = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic [CW-1:0] rx_level;
  logic          flush = 1'b0;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          idle;
  logic          spi_start;
  logic [7:0]    spi_data;
  logic          spi_dc;
  logic          spi_end_txn;
  logic          spi_busy = 1'b0;
  logic [7:0]    spi_rx = '0;

  tqvp_spi_fifo #(.DEPTH(DEPTH), .RX_CAPTURE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_dc(tx_dc), .tx_end(tx_end),
    .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .flush(flush), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .idle(idle),
    .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc),
    .spi_end_txn(spi_end_txn), .spi_busy(spi_busy), .spi_rx(spi_rx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [9:0] exp_tx[$];
  logic [7:0] rx_exp[$];
  bit m_rx_ovf = 0;

  bit active = 0;
  bit drop_next = 0;
  bit force_busy = 0;
  bit long_xfer = 0;
  bit pop_cap = 0;
  bit rx_auto = 0;
  bit chk_rx = 0;
  bit flush_req = 0;
  int pop_req = 0;
  int rem = 0;
  int npush = 0;
  int nstart = 0;
  bit prev_start = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic dc,
                      input logic e, input bit acc);
    tx_wr = 1'b1;
    tx_data = d;
    tx_dc = dc;
    tx_end = e;
    if (acc) begin
      exp_tx.push_back({dc, e, d});
      npush++;
    end
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (idle && exp_tx.size() == 0 && !active) ok = 1;
    end
    if (!ok) check(nm, 0, 1);
  endtask

  task automatic wait_busy(input string nm);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (spi_busy) ok = 1;
    end
    if (!ok) check(nm, 0, 1);
    @(negedge clk);
  endtask

  // Start monitor: every start pulse must carry the next expected byte
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 0;
    end else begin
      if (spi_start) begin
        check("start_width", 32'(prev_start), 0);
        if (exp_tx.size() == 0) check("unexp_start", 1, 0);
        else check("start_byte", {spi_dc, spi_end_txn, spi_data},
                   exp_tx.pop_front());
        nstart++;
      end
      prev_start = spi_start;
    end
  end

  // SPI controller model plus RX scoreboard (owns rx_rd, flush and the RX model)
  always @(negedge clk) begin
    bit completing;
    rx_rd = 1'b0;
    flush = 1'b0;
    if (!rst_n) begin
      spi_busy = 1'b0;
      active = 0;
      rem = 0;
      drop_next = 0;
      pop_cap = 0;
    end else begin
      if (chk_rx) begin
        check("rx_level", rx_level, rx_exp.size());
        check("rx_empty", rx_empty, rx_exp.size() == 0);
        check("rx_ovf", rx_ovf, m_rx_ovf);
      end
      completing = active && !force_busy && rem <= 1;
      if (flush_req) begin
        flush = 1'b1;
        flush_req = 0;
        exp_tx.delete();
        rx_exp.delete();
        m_rx_ovf = 0;
        drop_next = active;
      end else if (rx_exp.size() > 0 &&
                   (pop_req > 0 || (pop_cap && completing) ||
                    (rx_auto && $urandom_range(0, 1) == 1))) begin
        check("rx_head", rx_data, rx_exp.pop_front());
        rx_rd = 1'b1;
        if (pop_req > 0) pop_req--;
      end else if (rx_auto && rx_exp.size() == 0 &&
                   $urandom_range(0, 3) == 0) begin
        rx_rd = 1'b1;
      end
      if (force_busy) begin
        spi_busy = 1'b1;
      end else if (completing) begin
        spi_busy = 1'b0;
        active = 0;
        spi_rx = 8'($urandom);
        if (drop_next) drop_next = 0;
        else if (rx_exp.size() < DEPTH) rx_exp.push_back(spi_rx);
        else m_rx_ovf = 1;
        pop_cap = 0;
      end else if (active) begin
        rem--;
      end else if (spi_busy) begin
        spi_busy = 1'b0;
      end else if (spi_start) begin
        spi_busy = 1'b1;
        active = 1;
        rem = long_xfer ? 8 : int'($urandom_range(1, 4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_level", rx_level, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_idle", idle, 1);
    check("rst_start", spi_start, 0);
    check("rst_data", spi_data, 0);
    check("rst_dc", spi_dc, 0);
    check("rst_end", spi_end_txn, 1);
    check("rst_ovf", {tx_ovf, rx_ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push(8'hA5, 1'b1, 1'b1, 1);
    check("lat_early", spi_start, 0);
    @(negedge clk);
    check("lat_start", spi_start, 1);
    wait_quiet("a5_to");
    check("a5_rx_level", rx_level, 1);
    pop_req = 1;
    for (int i = 0; i < 20 && pop_req > 0; i++) @(negedge clk);
    check("a5_pop_done", pop_req, 0);
    pop_req = 0;
    @(negedge clk);
    check("a5_rx_empty", rx_empty, 1);

    force_busy = 1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0, i == 4, 1);
    check("ovf_full", tx_full, 1);
    check("ovf_lvl4", tx_level, 4);
    push(8'h05, 1'b0, 1'b0, 0);
    check("ovf_flag", tx_ovf, 1);
    check("ovf_lvl_keep", tx_level, 4);
    check("ovf_not_idle", idle, 0);
    force_busy = 0;
    wait_quiet("burst_to");
    check("burst_rx_lvl", rx_level, 4);
    check("burst_rx_ovf", rx_ovf, 0);
    check("tx_ovf_sticky", tx_ovf, 1);

    pop_cap = 1;
    push(8'h06, 1'b1, 1'b0, 1);
    wait_quiet("popcap_to");
    check("popcap_lvl", rx_level, 4);
    check("popcap_ovf", rx_ovf, 0);
    check("popcap_head", rx_data, rx_exp.size() > 0 ? rx_exp[0] : 8'hxx);

    push(8'h07, 1'b0, 1'b1, 1);
    wait_quiet("rxovf_to");
    check("rxovf_lvl", rx_level, 4);
    check("rxovf_flag", rx_ovf, 1);
    check("rxovf_head", rx_data, rx_exp.size() > 0 ? rx_exp[0] : 8'hxx);

    long_xfer = 1;
    push(8'h11, 1'b0, 1'b0, 1);
    push(8'h12, 1'b0, 1'b0, 1);
    push(8'h13, 1'b0, 1'b1, 1);
    wait_busy("flush_busy_to");
    check("flush_pre_lvl", tx_level, 2);
    flush_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("flush_tx_lvl", tx_level, 0);
    check("flush_rx_lvl", rx_level, 0);
    check("flush_ovfs", {tx_ovf, rx_ovf}, 0);
    long_xfer = 0;
    wait_quiet("flush_to");
    check("flush_no_cap", rx_level, 0);
    check("flush_idle", idle, 1);

    long_xfer = 1;
    push(8'h21, 1'b1, 1'b0, 1);
    wait_busy("rst_busy_to");
    #2;
    rst_n = 1'b0;
    exp_tx.delete();
    rx_exp.delete();
    m_rx_ovf = 0;
    #1;
    check("arst_start", spi_start, 0);
    check("arst_data", spi_data, 0);
    check("arst_flags", {spi_dc, spi_end_txn}, 2'b01);
    check("arst_idle", idle, 1);
    check("arst_levels", {tx_level, rx_level}, 0);
    check("arst_rx_empty", rx_empty, 1);
    @(negedge clk);
    @(negedge clk);
    long_xfer = 0;
    npush = 0;
    nstart = 0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", idle, 1);
    check("post_rst_starts", nstart, 0);

    rx_auto = 1;
    chk_rx = 1;
    for (int c = 0; c < 400; c++) begin
      if ((npush - nstart) < DEPTH && $urandom_range(0, 2) == 0)
        push(8'($urandom), 1'($urandom), 1'($urandom), 1);
      else
        @(negedge clk);
    end
    wait_quiet("rand_to");
    for (int i = 0; i < 100 && rx_exp.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("rand_rx_drained", rx_level, 0);
    check("rand_tx_drained", tx_level, 0);
    check("rand_start_count", nstart, npush);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
